// File: rtl/spi_ram_arbiter.sv
// Shares one single-port synchronous RAM between an SPI command stream and a local
// requester, with round-robin arbitration and a one-entry SPI pending buffer.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 loc_req,
  input  logic                 loc_we,
  input  logic [ADDR_SIZE-1:0] loc_addr,
  input  logic [DATA_SIZE-1:0] loc_wdata,
  output logic                 loc_gnt,
  output logic [DATA_SIZE-1:0] loc_rdata,
  output logic                 loc_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 spi_ovf
);

  typedef enum logic [1:0] {StIdle, StRdSpi, StRdLoc} state_e;

  state_e               state_q, state_d;
  logic                 prio_loc_q, prio_loc_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 spi_pend_q, spi_pend_d;
  logic                 pend_we_q, pend_we_d;
  logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_SIZE-1:0] pend_data_q, pend_data_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_SIZE-1:0] loc_rdata_q, loc_rdata_d;
  logic                 loc_rvalid_q, loc_rvalid_d;
  logic                 spi_ovf_q, spi_ovf_d;

  logic                 grant_spi, grant_loc, spi_accept;
  logic [1:0]           cmd;
  logic [DATA_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] payload_addr;

  assign cmd          = rx_data[DATA_SIZE+1:DATA_SIZE];
  assign payload      = rx_data[DATA_SIZE-1:0];
  assign payload_addr = ADDR_SIZE'(payload);

  // Gating with rst_n keeps the RAM port quiet while reset is held, even with loc_req high.
  always_comb begin
    grant_spi = 1'b0;
    grant_loc = 1'b0;
    if (rst_n && state_q == StIdle) begin
      if (spi_pend_q && (!loc_req || !prio_loc_q)) begin
        grant_spi = 1'b1;
      end else if (loc_req) begin
        grant_loc = 1'b1;
      end
    end
  end

  assign mem_en    = grant_spi | grant_loc;
  assign mem_we    = grant_spi ? pend_we_q : (grant_loc & loc_we);
  assign mem_addr  = grant_spi ? pend_addr_q : loc_addr;
  assign mem_wdata = grant_spi ? pend_data_q : loc_wdata;
  assign loc_gnt   = grant_loc;

  // A full buffer can still take a new access if it drains this very cycle.
  assign spi_accept = !spi_pend_q || grant_spi;

  always_comb begin
    spi_pend_d  = spi_pend_q & ~grant_spi;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    spi_ovf_d   = spi_ovf_q;
    if (rx_valid) begin
      unique case (cmd)
        2'b00: wr_addr_d = payload_addr;
        2'b01: begin
          if (spi_accept) begin
            spi_pend_d  = 1'b1;
            pend_we_d   = 1'b1;
            pend_addr_d = wr_addr_q;
            pend_data_d = payload;
            wr_addr_d   = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            spi_ovf_d = 1'b1;
          end
        end
        2'b10: rd_addr_d = payload_addr;
        2'b11: begin
          if (spi_accept) begin
            spi_pend_d  = 1'b1;
            pend_we_d   = 1'b0;
            pend_addr_d = rd_addr_q;
            pend_data_d = '0;
            rd_addr_d   = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            spi_ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = StIdle;
    prio_loc_d   = prio_loc_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    loc_rdata_d  = loc_rdata_q;
    loc_rvalid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_spi) begin
          prio_loc_d = 1'b1;
          if (!pend_we_q) state_d = StRdSpi;
        end else if (grant_loc) begin
          prio_loc_d = 1'b0;
          if (!loc_we) state_d = StRdLoc;
        end
      end
      StRdSpi: begin
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
      end
      StRdLoc: begin
        loc_rdata_d  = mem_rdata;
        loc_rvalid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prio_loc_q   <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      spi_pend_q   <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      loc_rdata_q  <= '0;
      loc_rvalid_q <= 1'b0;
      spi_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_loc_q   <= prio_loc_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      spi_pend_q   <= spi_pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      loc_rdata_q  <= loc_rdata_d;
      loc_rvalid_q <= loc_rvalid_d;
      spi_ovf_q    <= spi_ovf_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign loc_rdata  = loc_rdata_q;
  assign loc_rvalid = loc_rvalid_q;
  assign spi_ovf    = spi_ovf_q;

endmodule
